// File: rtl/risc16_ctrl_fsm_if.sv
// Control/handshake bundle between the RISC16 controller and its datapath/memory.
// The master side is the controller; the slave side is the datapath that consumes the controls.
interface risc16_ctrl_fsm_if;
  logic [15:0] instruction;
  logic        eq;
  logic        mem_ready;
  logic        mem_req;
  logic        mem_we;
  logic        MUX_addr;
  logic        WE_ir;
  logic        WE_pc;
  logic [1:0]  MUX_pc;
  logic        FUNC_alu;
  logic        MUX_aluB;
  logic        MUX_rf;
  logic [1:0]  MUX_tgt;
  logic        WE_rf;

  modport master (
    input  instruction, eq, mem_ready,
    output mem_req, mem_we, MUX_addr, WE_ir, WE_pc, MUX_pc,
           FUNC_alu, MUX_aluB, MUX_rf, MUX_tgt, WE_rf
  );

  modport slave (
    output instruction, eq, mem_ready,
    input  mem_req, mem_we, MUX_addr, WE_ir, WE_pc, MUX_pc,
           FUNC_alu, MUX_aluB, MUX_rf, MUX_tgt, WE_rf
  );
endinterface

// File: rtl/risc16_ctrl_fsm.sv
// Multi-cycle RISC16 control unit: FETCH/DECODE/EXEC/MEM/WB sequencing with
// Moore-style control decode and a retired-instruction counter.
module risc16_ctrl_fsm (
  input  logic                      clk,
  input  logic                      rst_n,
  risc16_ctrl_fsm_if.master         bus,
  output logic [15:0]               retired,
  output logic [2:0]                state_dbg
);

  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5
  } state_e;

  localparam logic [2:0] OP_NAND = 3'b010;
  localparam logic [2:0] OP_LW   = 3'b100;
  localparam logic [2:0] OP_SW   = 3'b101;
  localparam logic [2:0] OP_BEQ  = 3'b110;
  localparam logic [2:0] OP_JALR = 3'b111;

  state_e      state_q, state_d;
  logic [15:0] retired_q, retired_d;

  logic [2:0] opcode;
  logic       is_nand, is_lw, is_sw, is_beq, is_jalr;
  logic       unused_instr_bits;

  assign opcode  = bus.instruction[15:13];
  assign is_nand = (opcode == OP_NAND);
  assign is_lw   = (opcode == OP_LW);
  assign is_sw   = (opcode == OP_SW);
  assign is_beq  = (opcode == OP_BEQ);
  assign is_jalr = (opcode == OP_JALR);
  assign unused_instr_bits = ^bus.instruction[12:0];

  // State register; reset is asynchronous so an aborted instruction drops mem_req at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_RESET;
      retired_q <= 16'd0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  // Next-state and retire counting
  always_comb begin
    state_d   = state_q;
    retired_d = retired_q;
    case (state_q)
      S_RESET:  state_d = S_FETCH;
      S_FETCH:  if (bus.mem_ready) state_d = S_DECODE;
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        if (is_lw || is_sw)        state_d = S_MEM;
        else if (is_beq || is_jalr) state_d = S_FETCH;
        else                        state_d = S_WB;
      end
      S_MEM: begin
        if (bus.mem_ready) state_d = is_sw ? S_FETCH : S_WB;
      end
      S_WB:     state_d = S_FETCH;
      default:  state_d = S_RESET;
    endcase
    // RESET->FETCH is not a retirement; every other entry into FETCH ends an instruction.
    if (state_d == S_FETCH &&
        (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB))
      retired_d = retired_q + 16'd1;
  end

  // Output decode
  always_comb begin
    bus.mem_req  = 1'b0;
    bus.mem_we   = 1'b0;
    bus.MUX_addr = 1'b0;
    bus.WE_ir    = 1'b0;
    bus.WE_pc    = 1'b0;
    bus.MUX_pc   = 2'b00;
    bus.FUNC_alu = 1'b0;
    bus.MUX_aluB = 1'b0;
    bus.MUX_rf   = 1'b0;
    bus.MUX_tgt  = 2'b00;
    bus.WE_rf    = 1'b0;
    case (state_q)
      S_FETCH: begin
        bus.mem_req = 1'b1;
        bus.WE_ir   = bus.mem_ready;
      end
      S_DECODE: begin
        bus.MUX_rf = is_sw || is_beq;
      end
      S_EXEC: begin
        bus.MUX_rf   = is_sw || is_beq;
        bus.FUNC_alu = is_nand;
        bus.MUX_aluB = is_sw;
        if (is_beq) begin
          bus.WE_pc  = 1'b1;
          bus.MUX_pc = bus.eq ? 2'b01 : 2'b00;
        end
        // jalr: the register file captures the old pc+1 on the same edge the PC moves.
        if (is_jalr) begin
          bus.WE_rf   = 1'b1;
          bus.MUX_tgt = 2'b10;
          bus.WE_pc   = 1'b1;
          bus.MUX_pc  = 2'b10;
        end
      end
      S_MEM: begin
        bus.mem_req  = 1'b1;
        bus.MUX_addr = 1'b1;
        bus.mem_we   = is_sw;
        bus.MUX_aluB = is_sw;
        bus.MUX_rf   = is_sw;
        bus.WE_pc    = is_sw && bus.mem_ready;
      end
      S_WB: begin
        bus.WE_rf   = 1'b1;
        bus.WE_pc   = 1'b1;
        bus.MUX_tgt = is_lw ? 2'b00 : 2'b01;
      end
      default: ;
    endcase
  end

  assign retired   = retired_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_risc16_ctrl_fsm.sv
// Self-checking bench for risc16_ctrl_fsm: per-cycle expected control vectors are
// queued when an instruction is scheduled and compared as the controller steps through it.
module tb_risc16_ctrl_fsm;

  logic        clk;
  logic        rst_n;
  logic [15:0] retired;
  logic [2:0]  state_dbg;

  risc16_ctrl_fsm_if bus();

  risc16_ctrl_fsm dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.master),
    .retired   (retired),
    .state_dbg (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rdy;
    logic        eq;
    logic [15:0] instr;
    logic [15:0] vec;
  } cyc_t;

  cyc_t        sb[$];
  int          checks   = 0;
  int          failures = 0;
  logic [15:0] exp_retired = 16'd0;
  logic [15:0] obs;

  assign obs = {state_dbg, bus.mem_req, bus.mem_we, bus.MUX_addr, bus.WE_ir, bus.WE_pc,
                bus.MUX_pc, bus.FUNC_alu, bus.MUX_aluB, bus.MUX_rf, bus.MUX_tgt, bus.WE_rf};

  function automatic logic [15:0] mk(input logic [2:0] st, input logic req, input logic we,
                                     input logic addr, input logic wir, input logic wpc,
                                     input logic [1:0] mpc, input logic fa, input logic ab,
                                     input logic mrf, input logic [1:0] tgt, input logic wrf);
    return {st, req, we, addr, wir, wpc, mpc, fa, ab, mrf, tgt, wrf};
  endfunction

  // Expected control vectors for one instruction, cycle by cycle.
  task automatic push_instr(input logic [15:0] ins, input logic e, input int fw, input int mw);
    logic [2:0] op;
    logic is_sw, is_lw, is_beq, is_jalr, is_nand, mrf;
    cyc_t c;
    op      = ins[15:13];
    is_nand = (op == 3'b010);
    is_lw   = (op == 3'b100);
    is_sw   = (op == 3'b101);
    is_beq  = (op == 3'b110);
    is_jalr = (op == 3'b111);
    mrf     = is_sw | is_beq;
    c.eq    = e;
    c.instr = ins;
    for (int i = 0; i < fw; i++) begin
      c.rdy = 1'b0;
      c.vec = mk(3'd1, 1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 2'b00, 0);
      sb.push_back(c);
    end
    c.rdy = 1'b1;
    c.vec = mk(3'd1, 1, 0, 0, 1, 0, 2'b00, 0, 0, 0, 2'b00, 0);
    sb.push_back(c);
    c.rdy = 1'($urandom_range(0, 1));
    c.vec = mk(3'd2, 0, 0, 0, 0, 0, 2'b00, 0, 0, mrf, 2'b00, 0);
    sb.push_back(c);
    c.rdy = 1'($urandom_range(0, 1));
    if (is_beq)
      c.vec = mk(3'd3, 0, 0, 0, 0, 1, e ? 2'b01 : 2'b00, 0, 0, 1, 2'b00, 0);
    else if (is_jalr)
      c.vec = mk(3'd3, 0, 0, 0, 0, 1, 2'b10, 0, 0, 0, 2'b10, 1);
    else
      c.vec = mk(3'd3, 0, 0, 0, 0, 0, 2'b00, is_nand, is_sw, mrf, 2'b00, 0);
    sb.push_back(c);
    if (is_lw || is_sw) begin
      for (int i = 0; i < mw; i++) begin
        c.rdy = 1'b0;
        c.vec = mk(3'd4, 1, is_sw, 1, 0, 0, 2'b00, 0, is_sw, is_sw, 2'b00, 0);
        sb.push_back(c);
      end
      c.rdy = 1'b1;
      c.vec = mk(3'd4, 1, is_sw, 1, 0, is_sw, 2'b00, 0, is_sw, is_sw, 2'b00, 0);
      sb.push_back(c);
    end
    if (!is_beq && !is_jalr && !is_sw) begin
      c.rdy = 1'($urandom_range(0, 1));
      c.vec = mk(3'd5, 0, 0, 0, 0, 1, 2'b00, 0, 0, 0, is_lw ? 2'b00 : 2'b01, 1);
      sb.push_back(c);
    end
    exp_retired = exp_retired + 16'd1;
    $display("instr op=%0d ir=%h eq=%0d fetch_wait=%0d mem_wait=%0d", op, ins, e, fw, mw);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.mem_ready = 1'b1;
    bus.eq = 1'b0;
    bus.instruction = 16'h0000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== 16'h0000) begin
        failures++; $display("FAIL reset_outputs: got %h want 0000", obs);
      end
      checks++;
      if (retired !== 16'd0) begin
        failures++; $display("FAIL reset_retired: got %h want 0000", retired);
      end
    end
    bus.mem_ready = 1'b0;
    rst_n = 1'b1;
    #1;
    checks++;
    if (state_dbg !== 3'd0 || bus.mem_req !== 1'b0) begin
      failures++; $display("FAIL reset_release: state %0d req %b want 0/0", state_dbg, bus.mem_req);
    end
    @(posedge clk); #1;
    checks++;
    if (state_dbg !== 3'd1 || bus.mem_req !== 1'b1) begin
      failures++; $display("FAIL reset_first_fetch: state %0d req %b want 1/1", state_dbg, bus.mem_req);
    end
    checks++;
    if (retired !== 16'd0) begin
      failures++; $display("FAIL reset_no_retire: got %h want 0000", retired);
    end
    exp_retired = 16'd0;
    $display("reset done");
  endtask

  task automatic test_alu();
    logic [15:0] ins [5];
    int          fw  [5];
    cyc_t c;
    ins[0] = 16'h0401; fw[0] = 0;
    ins[1] = 16'h2A85; fw[1] = 0;
    ins[2] = 16'h4C12; fw[2] = 0;
    ins[3] = 16'h7F80; fw[3] = 0;
    ins[4] = 16'h0123; fw[4] = 1;
    for (int k = 0; k < 5; k++) begin
      push_instr(ins[k], 1'b0, fw[k], 0);
      while (sb.size() > 0) begin
        c = sb.pop_front();
        @(negedge clk);
        bus.mem_ready = c.rdy; bus.eq = c.eq; bus.instruction = c.instr;
        #1;
        checks++;
        if (obs !== c.vec) begin
          failures++; $display("FAIL alu_cycle ir=%h: got %h want %h", c.instr, obs, c.vec);
        end
      end
      @(posedge clk); #1;
      checks++;
      if (retired !== exp_retired) begin
        failures++; $display("FAIL alu_retired: got %h want %h", retired, exp_retired);
      end
    end
  endtask

  task automatic test_lw_wait();
    cyc_t c;
    push_instr(16'h8B07, 1'b0, 0, 2);
    while (sb.size() > 0) begin
      c = sb.pop_front();
      @(negedge clk);
      bus.mem_ready = c.rdy; bus.eq = c.eq; bus.instruction = c.instr;
      #1;
      checks++;
      if (obs !== c.vec) begin
        failures++; $display("FAIL lw_cycle: got %h want %h", obs, c.vec);
      end
    end
    @(posedge clk); #1;
    checks++;
    if (retired !== exp_retired || state_dbg !== 3'd1) begin
      failures++; $display("FAIL lw_end: retired %h state %0d want %h/1", retired, state_dbg, exp_retired);
    end
  endtask

  task automatic test_sw();
    cyc_t c;
    push_instr(16'hA905, 1'b0, 0, 0);
    push_instr(16'hB2FF, 1'b1, 2, 1);
    while (sb.size() > 0) begin
      c = sb.pop_front();
      @(negedge clk);
      bus.mem_ready = c.rdy; bus.eq = c.eq; bus.instruction = c.instr;
      #1;
      checks++;
      if (obs !== c.vec) begin
        failures++; $display("FAIL sw_cycle: got %h want %h", obs, c.vec);
      end
    end
    @(posedge clk); #1;
    checks++;
    if (retired !== exp_retired) begin
      failures++; $display("FAIL sw_retired: got %h want %h", retired, exp_retired);
    end
  endtask

  task automatic test_branch();
    logic [15:0] ins [3];
    logic        e   [3];
    cyc_t c;
    ins[0] = 16'hC47F; e[0] = 1'b1;
    ins[1] = 16'hC47F; e[1] = 1'b0;
    ins[2] = 16'hE480; e[2] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      push_instr(ins[k], e[k], 0, 0);
      while (sb.size() > 0) begin
        c = sb.pop_front();
        @(negedge clk);
        bus.mem_ready = c.rdy; bus.eq = c.eq; bus.instruction = c.instr;
        #1;
        checks++;
        if (obs !== c.vec) begin
          failures++; $display("FAIL branch_cycle ir=%h eq=%b: got %h want %h", c.instr, c.eq, obs, c.vec);
        end
      end
      @(posedge clk); #1;
      checks++;
      if (retired !== exp_retired) begin
        failures++; $display("FAIL branch_retired: got %h want %h", retired, exp_retired);
      end
    end
  endtask

  task automatic test_wrap();
    cyc_t c;
    force dut.retired_q = 16'hFFFF;
    #1;
    release dut.retired_q;
    #1;
    checks++;
    if (retired !== 16'hFFFF) begin
      failures++; $display("FAIL wrap_preload: got %h want ffff", retired);
    end
    exp_retired = 16'hFFFF;
    push_instr(16'hC000, 1'b0, 0, 0);
    while (sb.size() > 0) begin
      c = sb.pop_front();
      @(negedge clk);
      bus.mem_ready = c.rdy; bus.eq = c.eq; bus.instruction = c.instr;
      #1;
      checks++;
      if (obs !== c.vec) begin
        failures++; $display("FAIL wrap_cycle: got %h want %h", obs, c.vec);
      end
    end
    @(posedge clk); #1;
    checks++;
    if (retired !== 16'h0000) begin
      failures++; $display("FAIL wrap_retired: got %h want 0000", retired);
    end
  endtask

  task automatic test_back_to_back();
    cyc_t c;
    for (int k = 0; k < 12; k++)
      push_instr(16'($urandom), 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
    while (sb.size() > 0) begin
      c = sb.pop_front();
      @(negedge clk);
      bus.mem_ready = c.rdy; bus.eq = c.eq; bus.instruction = c.instr;
      #1;
      checks++;
      if (obs !== c.vec) begin
        failures++; $display("FAIL b2b_cycle ir=%h: got %h want %h", c.instr, obs, c.vec);
      end
    end
    @(posedge clk); #1;
    checks++;
    if (retired !== exp_retired) begin
      failures++; $display("FAIL b2b_retired: got %h want %h", retired, exp_retired);
    end
  endtask

  task automatic test_async_reset();
    cyc_t c;
    bus.instruction = 16'h8000;
    @(negedge clk); bus.mem_ready = 1'b1;
    @(negedge clk); bus.mem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk); #1;
    checks++;
    if (state_dbg !== 3'd4 || bus.mem_req !== 1'b1) begin
      failures++; $display("FAIL async_in_mem: state %0d req %b want 4/1", state_dbg, bus.mem_req);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.mem_req !== 1'b0 || state_dbg !== 3'd0 || retired !== 16'd0) begin
      failures++; $display("FAIL async_abort: req %b state %0d retired %h want 0/0/0",
                           bus.mem_req, state_dbg, retired);
    end
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      checks++;
      if (obs !== 16'h0000) begin
        failures++; $display("FAIL async_hold: got %h want 0000", obs);
      end
    end
    bus.mem_ready = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    exp_retired = 16'd0;
    $display("async reset done");
    push_instr(16'h0401, 1'b0, 0, 0);
    while (sb.size() > 0) begin
      c = sb.pop_front();
      @(negedge clk);
      bus.mem_ready = c.rdy; bus.eq = c.eq; bus.instruction = c.instr;
      #1;
      checks++;
      if (obs !== c.vec) begin
        failures++; $display("FAIL recover_cycle: got %h want %h", obs, c.vec);
      end
    end
    @(posedge clk); #1;
    checks++;
    if (retired !== exp_retired) begin
      failures++; $display("FAIL recover_retired: got %h want %h", retired, exp_retired);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_lw_wait();
    test_sw();
    test_branch();
    test_wrap();
    test_back_to_back();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/risc16_ctrl_fsm.md
# risc16_ctrl_fsm

Multi-cycle control unit for the 16-bit RISC core (8 opcodes in instruction[15:13]). It is the initiator that drives the register file's read-select and write-back controls (MUX_rf, MUX_tgt, WE_rf), the PC, the IR and the memory handshake. It sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states and counts retired instructions.

## Interface
- No parameters; opcodes fixed: add 000, addi 001, nand 010, lui 011, lw 100, sw 101, beq 110, jalr 111.
- clk  in  1  single clock; all state on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- instruction  in  16  IR contents; valid from DECODE onward.
- eq  in  1  datapath compare, reg_out1 == reg_out2.
- mem_ready  in  1  memory completes current request this cycle.
- mem_req  out  1  memory request, held until mem_ready.
- mem_we  out  1  1 = write (sw), 0 = read.
- MUX_addr  out  1  memory address: 0 = pc, 1 = alu_out.
- WE_ir  out  1  load IR from memory data.
- WE_pc  out  1  update PC.
- MUX_pc  out  2  00 = pc+1, 01 = pc+1+sext(imm7), 10 = reg_out1.
- FUNC_alu  out  1  0 = add, 1 = nand.
- MUX_aluB  out  1  ALU B input: 0 = reg_out2, 1 = sext(imm7).
- MUX_rf  out  1  register-file second read: 0 = rC, 1 = rA.
- MUX_tgt  out  2  write-back source: 00 = mem_out, 01 = alu_out, 10 = pc+1.
- WE_rf  out  1  register-file write enable.
- retired  out  16  retired-instruction count.
- state_dbg  out  3  current state encoding.

## Operation
- States: RESET=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5.
- Outputs are Moore-style, decoded from the state and the opcode. Exception: in FETCH and MEM, WE_ir and WE_pc are qualified by mem_ready.
- Any output not listed for a state is 0.
- RESET: all outputs 0. Goes to FETCH on the next clk.
- FETCH: mem_req=1, mem_we=0, MUX_addr=0.
  - mem_ready=0: stay in FETCH.
  - mem_ready=1: WE_ir=1, go to DECODE.
- DECODE: one cycle for operand settling. MUX_rf=1 for sw/beq, 0 otherwise. Always goes to EXEC.
- EXEC: MUX_rf as in DECODE. FUNC_alu=1 for nand only. MUX_aluB=1 for sw.
  - add/addi/nand/lui: go to WB.
  - lw/sw: go to MEM.
  - beq: WE_pc=1; MUX_pc=01 if eq else 00; go to FETCH.
  - jalr: WE_rf=1, MUX_tgt=10, WE_pc=1, MUX_pc=10; go to FETCH. The register file samples the old pc+1 on the same edge that the PC updates.
- MEM: mem_req=1, MUX_addr=1, mem_we=1 for sw. MUX_aluB=1 for sw; MUX_rf=1 for sw.
  - mem_ready=0: stay in MEM.
  - sw with mem_ready=1: WE_pc=1, MUX_pc=00, go to FETCH.
  - lw with mem_ready=1: go to WB.
- WB: WE_rf=1, WE_pc=1, MUX_pc=00; go to FETCH.
  - MUX_tgt=00 for lw, 01 otherwise.
  - lui uses an add of imm<<6 with 0 (FUNC_alu=0).
- The controller asserts WE_rf even when rA=0. Suppressing writes to r0 is the register file's job.
- retired increments by 1 on every transition into FETCH from EXEC, MEM or WB. It does not increment on RESET→FETCH. It wraps 0xFFFF→0x0000.

## Timing
- Reset: while rst_n=0, state=RESET, retired=0 and all outputs are 0, regardless of clk.
  - Reset asserted mid-instruction aborts it immediately: mem_req drops asynchronously and no WE_* pulse follows.
  - First mem_req is asserted one cycle after the rst_n deassertion edge.
- Latency with zero-wait memory (mem_ready=1 in the request cycle):
  - add/addi/nand/lui: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - beq, jalr: 3 cycles.
- Memory wait states extend FETCH/MEM one cycle each. mem_req, mem_we and MUX_addr stay stable throughout the wait.
- Exactly one WE_pc pulse per instruction, and at most one WE_rf pulse.
- WE_ir is asserted only in FETCH, in the mem_ready cycle.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with mem_ready=1 -> all outputs 0 and retired=0. Release -> RESET then FETCH, with mem_req=1 on the 2nd cycle.
- ALU ops, zero-wait: add (0x0401) -> state sequence 1,2,3,5. In WB, WE_rf=1, MUX_tgt=01, MUX_pc=00, and retired increments by 1 at the end of the instruction. Repeat for nand -> FUNC_alu=1 in EXEC.
- lw with 2 wait states in MEM -> MEM lasts 3 cycles with mem_req=1 and mem_we=0. WB then has MUX_tgt=00. Total 7 cycles.
- sw -> MUX_rf=1 and MUX_aluB=1 in EXEC/MEM, mem_we=1. WE_pc pulses on the mem_ready cycle, and WE_rf stays 0 throughout.
- beq with eq=1 -> MUX_pc=01. With eq=0 -> MUX_pc=00. Both take 3 cycles and have no WE_rf. jalr -> WE_rf=1, MUX_tgt=10, MUX_pc=10 in the same EXEC cycle.
- Preload retired=0xFFFF via 65535 single-cycle-memory beqs (or force) -> next retire gives 0x0000. Assert rst_n=0 mid-MEM -> mem_req falls without waiting for a clk edge.
